// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares one scoreboard write-back port among NR_REQ variable-latency FUs.
// Each requester owns a one-entry holding slot, so an FU only has to wait
// when its own slot is still occupied. Slots are drained round-robin, one per
// cycle, onto the write-back lane.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            drops every pending result and blocks new ones
//   req_valid_i        per-FU result present
//   req_ready_o        per-FU slot can take a result this cycle
//   req_tid_i          per-FU transaction id (flattened, NR_REQ*TRANS_ID_BITS)
//   req_data_i         per-FU result data (flattened, NR_REQ*XLEN)
//   req_ex_v_i         per-FU exception valid
//   req_ex_cause_i     per-FU exception cause (flattened, NR_REQ*XLEN)
//   wb_valid_o         write-back valid to the scoreboard
//   wb_tid_o           write-back transaction id
//   wb_data_o          write-back data
//   wb_ex_v_o          write-back exception valid
//   wb_ex_cause_o      write-back exception cause
//   pending_o          number of occupied slots
module wb_port_arbiter #(
  parameter int NR_REQ        = 4,
  parameter int TRANS_ID_BITS = 3,
  parameter int XLEN          = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NR_REQ-1:0]               req_valid_i,
  output logic [NR_REQ-1:0]               req_ready_o,
  input  logic [NR_REQ*TRANS_ID_BITS-1:0] req_tid_i,
  input  logic [NR_REQ*XLEN-1:0]          req_data_i,
  input  logic [NR_REQ-1:0]               req_ex_v_i,
  input  logic [NR_REQ*XLEN-1:0]          req_ex_cause_i,
  output logic                            wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]        wb_tid_o,
  output logic [XLEN-1:0]                 wb_data_o,
  output logic                            wb_ex_v_o,
  output logic [XLEN-1:0]                 wb_ex_cause_o,
  output logic [$clog2(NR_REQ+1)-1:0]     pending_o
);

  localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CW = $clog2(NR_REQ + 1);

  logic [NR_REQ-1:0]        slot_v_q, slot_v_d;
  logic [TRANS_ID_BITS-1:0] tid_q      [NR_REQ];
  logic [TRANS_ID_BITS-1:0] tid_d      [NR_REQ];
  logic [XLEN-1:0]          data_q     [NR_REQ];
  logic [XLEN-1:0]          data_d     [NR_REQ];
  logic [NR_REQ-1:0]        ex_v_q, ex_v_d;
  logic [XLEN-1:0]          ex_cause_q [NR_REQ];
  logic [XLEN-1:0]          ex_cause_d [NR_REQ];
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [PW-1:0]            grant_idx;
  logic                     grant_any;
  logic [NR_REQ-1:0]        grant;
  logic [NR_REQ-1:0]        accept;
  logic [CW-1:0]            pending_cnt;

  // Round-robin pick: first scan slots at or above rr_ptr, then wrap to the
  // slots below it. This avoids modulo arithmetic for non-power-of-2 NR_REQ.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    grant     = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!grant_any && slot_v_q[i] && (PW'(i) >= rr_ptr_q)) begin
        grant_idx = PW'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      if (!grant_any && slot_v_q[i] && (PW'(i) < rr_ptr_q)) begin
        grant_idx = PW'(i);
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // A slot being drained this cycle counts as free, so a lone FU can stream.
  assign req_ready_o = {NR_REQ{~flush_i}} & (~slot_v_q | grant);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      pending_cnt = pending_cnt + CW'(slot_v_q[i]);
    end
  end

  assign pending_o     = pending_cnt;
  assign wb_valid_o    = grant_any;
  assign wb_tid_o      = grant_any ? tid_q[grant_idx]      : '0;
  assign wb_data_o     = grant_any ? data_q[grant_idx]     : '0;
  assign wb_ex_v_o     = grant_any ? ex_v_q[grant_idx]     : 1'b0;
  assign wb_ex_cause_o = grant_any ? ex_cause_q[grant_idx] : '0;

  // Drain the granted slot, then let a same-cycle accept refill it. Flush
  // overrides both; the pointer only advances on a grant outside a flush.
  always_comb begin
    slot_v_d   = slot_v_q;
    tid_d      = tid_q;
    data_d     = data_q;
    ex_v_d     = ex_v_q;
    ex_cause_d = ex_cause_q;
    rr_ptr_d   = rr_ptr_q;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant[i]) begin
        slot_v_d[i] = 1'b0;
      end
      if (accept[i]) begin
        slot_v_d[i]   = 1'b1;
        tid_d[i]      = req_tid_i[i*TRANS_ID_BITS +: TRANS_ID_BITS];
        data_d[i]     = req_data_i[i*XLEN +: XLEN];
        ex_v_d[i]     = req_ex_v_i[i];
        ex_cause_d[i] = req_ex_cause_i[i*XLEN +: XLEN];
      end
    end
    if (flush_i) begin
      slot_v_d = '0;
    end else if (grant_any) begin
      rr_ptr_d = (grant_idx == PW'(NR_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_v_q <= '0;
      ex_v_q   <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NR_REQ; i++) begin
        tid_q[i]      <= '0;
        data_q[i]     <= '0;
        ex_cause_q[i] <= '0;
      end
    end else begin
      slot_v_q   <= slot_v_d;
      ex_v_q     <= ex_v_d;
      rr_ptr_q   <= rr_ptr_d;
      tid_q      <= tid_d;
      data_q     <= data_d;
      ex_cause_q <= ex_cause_d;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(grant));
  a_wb_from_valid_slot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    wb_valid_o |-> slot_v_q[grant_idx]);
  a_pending_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    pending_o <= CW'(NR_REQ));

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int NR = 4;
   localparam int TB = 3;
   localparam int XL = 64;

   logic            clk;
   logic            rstN;
   logic            flush;
   logic [NR-1:0]   reqValid;
   logic [NR-1:0]   reqReady;
   logic [NR*TB-1:0] reqTid;
   logic [NR*XL-1:0] reqData;
   logic [NR-1:0]   reqExV;
   logic [NR*XL-1:0] reqExCause;
   logic            wbValid;
   logic [TB-1:0]   wbTid;
   logic [XL-1:0]   wbData;
   logic            wbExV;
   logic [XL-1:0]   wbExCause;
   logic [2:0]      pending;

   int errorCount = 0;
   int checkCount = 0;

   wb_port_arbiter #(.NR_REQ(NR), .TRANS_ID_BITS(TB), .XLEN(XL)) dut (
      .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
      .req_valid_i(reqValid), .req_ready_o(reqReady),
      .req_tid_i(reqTid), .req_data_i(reqData),
      .req_ex_v_i(reqExV), .req_ex_cause_i(reqExCause),
      .wb_valid_o(wbValid), .wb_tid_o(wbTid), .wb_data_o(wbData),
      .wb_ex_v_o(wbExV), .wb_ex_cause_o(wbExCause), .pending_o(pending)
   );

   // Free-running 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents a result on FU idx
   task automatic applyStimulus(input int idx, input logic [2:0] tid, input logic [63:0] data,
                                input logic exV, input logic [63:0] cause);
      reqValid[idx]          = 1'b1;
      reqTid[idx*TB +: TB]   = tid;
      reqData[idx*XL +: XL]  = data;
      reqExV[idx]            = exV;
      reqExCause[idx*XL +: XL] = cause;
   endtask

   task automatic clearAll();
      reqValid   = '0;
      reqTid     = '0;
      reqData    = '0;
      reqExV     = '0;
      reqExCause = '0;
   endtask

   // Advance one clock; outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      clearAll();
      flush = 1'b0;
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      tick();
   endtask

   initial begin
      rstN = 1'b1;
      flush = 1'b0;
      clearAll();

      // Test 1: reset values, then single result round trip
      @(negedge clk);
      rstN = 1'b0;
      #2;
      checkOutput("rst_wb_valid", 64'(wbValid), 64'd0);
      checkOutput("rst_pending", 64'(pending), 64'd0);
      checkOutput("rst_ready", 64'(reqReady), 64'hF);
      checkOutput("rst_wb_tid", 64'(wbTid), 64'd0);
      checkOutput("rst_wb_data", wbData, 64'd0);
      doReset();
      applyStimulus(0, 3'd2, 64'hAB, 1'b0, 64'd0);
      tick();
      clearAll();
      checkOutput("t1_wb_valid", 64'(wbValid), 64'd1);
      checkOutput("t1_wb_tid", 64'(wbTid), 64'd2);
      checkOutput("t1_wb_data", wbData, 64'hAB);
      checkOutput("t1_pending", 64'(pending), 64'd1);
      tick();
      checkOutput("t1_wb_valid_after", 64'(wbValid), 64'd0);
      checkOutput("t1_pending_after", 64'(pending), 64'd0);

      // Test 2: all four FUs at once, drained in order 0..3
      doReset();
      for (int i = 0; i < NR; i++) begin
         applyStimulus(i, 3'(i), 64'h100 + 64'(i), (i == 2), (i == 2) ? 64'hC : 64'd0);
      end
      tick();
      clearAll();
      checkOutput("t2_full_ready", 64'(reqReady), 64'h1);
      for (int i = 0; i < NR; i++) begin
         checkOutput("t2_wb_valid", 64'(wbValid), 64'd1);
         checkOutput("t2_wb_tid", 64'(wbTid), 64'(i));
         checkOutput("t2_wb_data", wbData, 64'h100 + 64'(i));
         checkOutput("t2_wb_ex_v", 64'(wbExV), (i == 2) ? 64'd1 : 64'd0);
         checkOutput("t2_wb_ex_cause", wbExCause, (i == 2) ? 64'hC : 64'd0);
         checkOutput("t2_pending", 64'(pending), 64'(NR - i));
         tick();
      end
      checkOutput("t2_wb_valid_end", 64'(wbValid), 64'd0);
      checkOutput("t2_pending_end", 64'(pending), 64'd0);

      // Test 3: FU1 streams one result per cycle
      doReset();
      for (int t = 0; t < 8; t++) begin
         applyStimulus(1, 3'(t), 64'h300 + 64'(t), 1'b0, 64'd0);
         checkOutput("t3_ready1", 64'(reqReady[1]), 64'd1);
         tick();
         checkOutput("t3_wb_tid", 64'(wbTid), 64'(t));
         checkOutput("t3_wb_valid", 64'(wbValid), 64'd1);
      end
      clearAll();
      tick();
      checkOutput("t3_wb_valid_end", 64'(wbValid), 64'd0);

      // Test 4: move rr_ptr to 3 via a grant of slot 2, then check the wrap
      doReset();
      applyStimulus(2, 3'd1, 64'h1, 1'b0, 64'd0);
      tick();
      clearAll();
      tick();
      applyStimulus(0, 3'd4, 64'h40, 1'b0, 64'd0);
      applyStimulus(3, 3'd6, 64'h60, 1'b0, 64'd0);
      tick();
      clearAll();
      checkOutput("t4_first_tid", 64'(wbTid), 64'd6);
      checkOutput("t4_first_ready", 64'(reqReady), 64'hE);
      tick();
      checkOutput("t4_second_tid", 64'(wbTid), 64'd4);
      checkOutput("t4_second_valid", 64'(wbValid), 64'd1);
      tick();
      checkOutput("t4_wb_valid_end", 64'(wbValid), 64'd0);

      // Test 5: flush drops held results and blocks new ones
      doReset();
      applyStimulus(1, 3'd1, 64'h11, 1'b0, 64'd0);
      applyStimulus(2, 3'd2, 64'h22, 1'b0, 64'd0);
      tick();
      clearAll();
      flush = 1'b1;
      applyStimulus(0, 3'd7, 64'h77, 1'b0, 64'd0);
      #1;
      checkOutput("t5_ready_flush", 64'(reqReady), 64'h0);
      checkOutput("t5_wb_valid_flush", 64'(wbValid), 64'd1);
      tick();
      flush = 1'b0;
      clearAll();
      checkOutput("t5_wb_valid_after", 64'(wbValid), 64'd0);
      checkOutput("t5_pending_after", 64'(pending), 64'd0);
      tick();
      checkOutput("t5_no_capture", 64'(wbValid), 64'd0);

      // Test 6: FU2 holds a new result until its old one drains
      doReset();
      applyStimulus(1, 3'd1, 64'h10, 1'b0, 64'd0);
      applyStimulus(2, 3'd3, 64'h30, 1'b0, 64'd0);
      tick();
      clearAll();
      applyStimulus(2, 3'd5, 64'h50, 1'b0, 64'd0);
      checkOutput("t6_ready2_held", 64'(reqReady[2]), 64'd0);
      checkOutput("t6_wb_tid_a", 64'(wbTid), 64'd1);
      tick();
      checkOutput("t6_wb_tid_b", 64'(wbTid), 64'd3);
      checkOutput("t6_ready2_granted", 64'(reqReady[2]), 64'd1);
      tick();
      clearAll();
      checkOutput("t6_wb_tid_c", 64'(wbTid), 64'd5);
      checkOutput("t6_wb_data_c", wbData, 64'h50);
      tick();
      checkOutput("t6_once", 64'(wbValid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
